// File: rtl/config_mem_pkg.sv
// Shared constants and helpers for the shadowed configuration memory:
// address sizing and one-hot / multi-hot strobe classification.
package config_mem_pkg;

  localparam int unsigned DefMaxFramesPerCol = 20;
  localparam int unsigned DefFrameBitsPerRow = 32;
  localparam int unsigned DefNoConfigBits    = 640;

  // Strobes are zero-extended to this width before classification.
  localparam int unsigned StrobeVecW = 256;

  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // s & (s - 1) clears the lowest set bit; non-zero means two or more bits set.
  function automatic logic is_onehot(input logic [StrobeVecW-1:0] s);
    return (s != '0) && ((s & (s - StrobeVecW'(1))) == '0);
  endfunction

  function automatic logic is_multihot(input logic [StrobeVecW-1:0] s);
    return (s & (s - StrobeVecW'(1))) != '0;
  endfunction

endpackage

// File: rtl/config_frame_reg.sv
// One configuration frame: shadow register written by frame loads, active
// register loaded on commit, and a dirty flag tracking uncommitted writes.
module config_frame_reg #(
  parameter int unsigned     Width    = 32,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic             commit_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] shadow_o,
  output logic [Width-1:0] active_o,
  output logic             dirty_o
);

  logic [Width-1:0] shadow_q, shadow_d;
  logic [Width-1:0] active_q, active_d;
  logic             dirty_q, dirty_d;

  // Commit copies the pre-edge shadow; a same-edge write lands after it and
  // keeps the frame dirty.
  always_comb begin
    shadow_d = we_i ? data_i : shadow_q;
    active_d = commit_i ? shadow_q : active_q;
    dirty_d  = we_i ? 1'b1 : (commit_i ? 1'b0 : dirty_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= ResetVal;
      active_q <= ResetVal;
      dirty_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      dirty_q  <= dirty_d;
    end
  end

  assign shadow_o = shadow_q;
  assign active_o = active_q;
  assign dirty_o  = dirty_q;

endmodule

// File: rtl/config_mem_shadow.sv
// Double-buffered configuration memory: frames load into a shadow copy and
// move to the active ConfigBits only on Commit; shadow frames can be read back.
module config_mem_shadow
  import config_mem_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = DefMaxFramesPerCol,
  parameter int unsigned FrameBitsPerRow = DefFrameBitsPerRow,
  parameter int unsigned NoConfigBits    = DefNoConfigBits,
  parameter logic [NoConfigBits-1:0] ResetBitstream = '0,
  localparam int unsigned AddrW = addr_width(MaxFramesPerCol)
) (
  input  logic                       UserCLK,
  input  logic                       Reset,
  input  logic [FrameBitsPerRow-1:0] FrameData,
  input  logic [MaxFramesPerCol-1:0] FrameStrobe,
  input  logic                       Commit,
  input  logic                       ReadReq,
  input  logic [AddrW-1:0]           ReadAddr,
  output logic [FrameBitsPerRow-1:0] ReadData,
  output logic                       ReadValid,
  output logic                       Dirty,
  output logic                       StrobeErr,
  output logic [NoConfigBits-1:0]    ConfigBits,
  output logic [NoConfigBits-1:0]    ConfigBits_N
);

  if (NoConfigBits < 1 || NoConfigBits > MaxFramesPerCol * FrameBitsPerRow ||
      MaxFramesPerCol > StrobeVecW) begin : g_param_err
    $error("config_mem_shadow: illegal NoConfigBits or MaxFramesPerCol");
  end

  logic [StrobeVecW-1:0]      strobe_ext;
  logic                       strobe_onehot;
  logic                       strobe_multi;
  logic [MaxFramesPerCol-1:0] write_en;
  logic [MaxFramesPerCol-1:0] dirty_bits;
  logic [FrameBitsPerRow-1:0] shadow_frames [MaxFramesPerCol];

  assign strobe_ext    = StrobeVecW'(FrameStrobe);
  assign strobe_onehot = is_onehot(strobe_ext);
  assign strobe_multi  = is_multihot(strobe_ext);
  assign write_en      = FrameStrobe & {MaxFramesPerCol{strobe_onehot}};

  for (genvar i = 0; i < MaxFramesPerCol; i++) begin : g_frame
    localparam int unsigned Base = i * FrameBitsPerRow;
    localparam int unsigned Used = (NoConfigBits <= Base) ? 0 :
        ((NoConfigBits - Base >= FrameBitsPerRow) ? FrameBitsPerRow : NoConfigBits - Base);

    // Frames entirely past NoConfigBits carry no storage and read back zero.
    if (Used > 0) begin : g_used
      logic [Used-1:0] shadow;
      logic [Used-1:0] active;

      config_frame_reg #(
        .Width    (Used),
        .ResetVal (ResetBitstream[Base +: Used])
      ) u_frame (
        .clk_i    (UserCLK),
        .rst_i    (Reset),
        .we_i     (write_en[i]),
        .commit_i (Commit),
        .data_i   (FrameData[Used-1:0]),
        .shadow_o (shadow),
        .active_o (active),
        .dirty_o  (dirty_bits[i])
      );

      assign ConfigBits[Base +: Used] = active;
      assign shadow_frames[i]         = FrameBitsPerRow'(shadow);
    end else begin : g_empty
      assign shadow_frames[i] = '0;
      assign dirty_bits[i]    = 1'b0;
    end
  end

  logic [FrameBitsPerRow-1:0] read_frame;
  logic [FrameBitsPerRow-1:0] read_data_q, read_data_d;
  logic                       read_valid_q;
  logic                       strobe_err_q;

  // Addresses past the last frame match nothing and return zero.
  always_comb begin
    read_frame = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      if (ReadAddr == AddrW'(i)) read_frame = shadow_frames[i];
    end
    read_data_d = ReadReq ? read_frame : read_data_q;
  end

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      strobe_err_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= ReadReq;
      strobe_err_q <= strobe_err_q | strobe_multi;
    end
  end

  assign ReadData     = read_data_q;
  assign ReadValid    = read_valid_q;
  assign StrobeErr    = strobe_err_q;
  assign Dirty        = |dirty_bits;
  assign ConfigBits_N = ~ConfigBits;

endmodule

// File: tb/tb_config_mem_shadow.sv
// Directed bench for config_mem_shadow: default build, a trimmed 40-bit
// build and a build with a non-zero reset bitstream.
module tb_config_mem_shadow;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Default instance
  logic         a_rst = 1'b1, a_commit = 1'b0, a_rreq = 1'b0;
  logic [31:0]  a_fdata = '0;
  logic [19:0]  a_strobe = '0;
  logic [4:0]   a_raddr = '0;
  logic [31:0]  a_rdata;
  logic         a_rvalid, a_dirty, a_serr;
  logic [639:0] a_cfg, a_cfg_n;

  config_mem_shadow u_dut_a (
    .UserCLK(clk), .Reset(a_rst), .FrameData(a_fdata), .FrameStrobe(a_strobe),
    .Commit(a_commit), .ReadReq(a_rreq), .ReadAddr(a_raddr), .ReadData(a_rdata),
    .ReadValid(a_rvalid), .Dirty(a_dirty), .StrobeErr(a_serr), .ConfigBits(a_cfg),
    .ConfigBits_N(a_cfg_n)
  );

  // 40 used bits: frame 1 trimmed to 8 bits, frames 2..19 empty
  logic        b_rst = 1'b1, b_commit = 1'b0, b_rreq = 1'b0;
  logic [31:0] b_fdata = '0;
  logic [19:0] b_strobe = '0;
  logic [4:0]  b_raddr = '0;
  logic [31:0] b_rdata;
  logic        b_rvalid, b_dirty, b_serr;
  logic [39:0] b_cfg, b_cfg_n;

  config_mem_shadow #(.NoConfigBits(40)) u_dut_b (
    .UserCLK(clk), .Reset(b_rst), .FrameData(b_fdata), .FrameStrobe(b_strobe),
    .Commit(b_commit), .ReadReq(b_rreq), .ReadAddr(b_raddr), .ReadData(b_rdata),
    .ReadValid(b_rvalid), .Dirty(b_dirty), .StrobeErr(b_serr), .ConfigBits(b_cfg),
    .ConfigBits_N(b_cfg_n)
  );

  localparam logic [639:0] RstA = {20{32'hAAAA_AAAA}};
  logic         c_rst = 1'b1, c_commit = 1'b0, c_rreq = 1'b0;
  logic [31:0]  c_fdata = '0;
  logic [19:0]  c_strobe = '0;
  logic [4:0]   c_raddr = '0;
  logic [31:0]  c_rdata;
  logic         c_rvalid, c_dirty, c_serr;
  logic [639:0] c_cfg, c_cfg_n;

  config_mem_shadow #(.ResetBitstream(RstA)) u_dut_c (
    .UserCLK(clk), .Reset(c_rst), .FrameData(c_fdata), .FrameStrobe(c_strobe),
    .Commit(c_commit), .ReadReq(c_rreq), .ReadAddr(c_raddr), .ReadData(c_rdata),
    .ReadValid(c_rvalid), .Dirty(c_dirty), .StrobeErr(c_serr), .ConfigBits(c_cfg),
    .ConfigBits_N(c_cfg_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    checks++; if (a_cfg !== '0) begin failures++;
      $display("FAIL reset_cfg actual=%h required=0", a_cfg[127:0]); end
    checks++; if (a_cfg_n !== {640{1'b1}}) begin failures++;
      $display("FAIL reset_cfg_n actual=%h required=all ones", a_cfg_n[127:0]); end
    checks++; if ({a_dirty, a_serr, a_rvalid} !== 3'b000) begin failures++;
      $display("FAIL reset_flags actual=%b required=000", {a_dirty, a_serr, a_rvalid}); end
    checks++; if (a_rdata !== 32'h0) begin failures++;
      $display("FAIL reset_rdata actual=%h required=00000000", a_rdata); end
    checks++; if (c_cfg !== RstA) begin failures++;
      $display("FAIL reset_bitstream actual=%h required=aaaaaaaa...", c_cfg[63:0]); end
    // Zero strobe with live data: no write, no error
    a_fdata = 32'h1234_5678;
    repeat (3) tick();
    a_fdata = '0;
    checks++; if ({a_dirty, a_serr} !== 2'b00) begin failures++;
      $display("FAIL zero_strobe actual=%b required=00", {a_dirty, a_serr}); end
  endtask

  task automatic test_write_commit();
    a_strobe = 20'h1 << 3; a_fdata = 32'hDEAD_BEEF;
    tick();
    a_strobe = '0; a_fdata = '0;
    checks++; if (a_dirty !== 1'b1) begin failures++;
      $display("FAIL write_dirty actual=%b required=1", a_dirty); end
    checks++; if (a_cfg[127:96] !== 32'h0) begin failures++;
      $display("FAIL write_no_active actual=%h required=00000000", a_cfg[127:96]); end
    a_commit = 1'b1;
    tick();
    a_commit = 1'b0;
    checks++; if (a_cfg[127:96] !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL commit_cfg actual=%h required=deadbeef", a_cfg[127:96]); end
    checks++; if (a_cfg_n[127:96] !== 32'h2152_4110) begin failures++;
      $display("FAIL commit_cfg_n actual=%h required=21524110", a_cfg_n[127:96]); end
    checks++; if (a_dirty !== 1'b0) begin failures++;
      $display("FAIL commit_dirty actual=%b required=0", a_dirty); end
    checks++; if (a_cfg_n !== ~a_cfg) begin failures++;
      $display("FAIL cfg_n_inverse actual=%h required=%h", a_cfg_n[127:96], ~a_cfg[127:96]); end
  endtask

  task automatic test_back_to_back_read();
    a_rreq = 1'b1; a_raddr = 5'd3;
    tick();
    a_raddr = 5'd25;
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL read_frame3 actual=%b/%h required=1/deadbeef", a_rvalid, a_rdata); end
    tick();
    a_rreq = 1'b0; a_raddr = 5'd3;
    checks++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin failures++;
      $display("FAIL read_oob actual=%b/%h required=1/00000000", a_rvalid, a_rdata); end
    a_rreq = 1'b1;
    tick();
    a_rreq = 1'b0;
    tick();
    checks++; if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL read_hold actual=%b/%h required=0/deadbeef", a_rvalid, a_rdata); end
  endtask

  task automatic test_strobe_err();
    a_strobe = 20'h00005; a_fdata = 32'hFFFF_FFFF;
    tick();
    a_strobe = '0; a_fdata = '0;
    checks++; if (a_serr !== 1'b1 || a_dirty !== 1'b0) begin failures++;
      $display("FAIL multihot_err actual=%b/%b required=1/0", a_serr, a_dirty); end
    repeat (10) tick();
    a_commit = 1'b1;
    tick();
    a_commit = 1'b0;
    checks++; if (a_serr !== 1'b1) begin failures++;
      $display("FAIL err_sticky actual=%b required=1", a_serr); end
    checks++; if (a_cfg[95:0] !== 96'h0 || a_cfg[127:96] !== 32'hDEAD_BEEF) begin failures++;
      $display("FAIL multihot_nowrite actual=%h required=deadbeef+0", a_cfg[127:0]); end
    a_rreq = 1'b1; a_raddr = 5'd2;
    tick();
    a_rreq = 1'b0;
    checks++; if (a_rdata !== 32'h0) begin failures++;
      $display("FAIL multihot_shadow actual=%h required=00000000", a_rdata); end
  endtask

  task automatic test_commit_with_write();
    a_strobe = 20'h1; a_fdata = 32'h1; a_commit = 1'b1;
    tick();
    a_strobe = '0; a_fdata = '0; a_commit = 1'b0;
    checks++; if (a_cfg[31:0] !== 32'h0 || a_dirty !== 1'b1) begin failures++;
      $display("FAIL same_edge actual=%h/%b required=00000000/1", a_cfg[31:0], a_dirty); end
    a_commit = 1'b1;
    tick();
    a_commit = 1'b0;
    checks++; if (a_cfg[31:0] !== 32'h1 || a_dirty !== 1'b0) begin failures++;
      $display("FAIL second_commit actual=%h/%b required=00000001/0", a_cfg[31:0], a_dirty); end
  endtask

  task automatic test_reset_override();
    a_strobe = 20'h1 << 7; a_fdata = 32'h5555_5555;
    tick();
    a_rreq = 1'b1; a_raddr = 5'd3; a_commit = 1'b1; a_strobe = 20'h1 << 8; a_rst = 1'b1;
    tick();
    a_rreq = 1'b0; a_commit = 1'b0; a_strobe = '0; a_fdata = '0; a_rst = 1'b0;
    checks++; if (a_cfg !== '0) begin failures++;
      $display("FAIL rst_override_cfg actual=%h required=0", a_cfg[287:0]); end
    checks++; if ({a_dirty, a_serr, a_rvalid} !== 3'b000 || a_rdata !== 32'h0) begin
      failures++;
      $display("FAIL rst_override_flags actual=%b/%h required=000/00000000",
               {a_dirty, a_serr, a_rvalid}, a_rdata);
    end
  endtask

  task automatic test_trimmed();
    b_strobe = 20'h2; b_fdata = 32'hFFFF_FFFF;
    tick();
    b_strobe = '0; b_fdata = '0; b_commit = 1'b1;
    tick();
    b_commit = 1'b0; b_rreq = 1'b1; b_raddr = 5'd1;
    tick();
    b_rreq = 1'b0;
    checks++; if (b_cfg !== 40'hFF_0000_0000) begin failures++;
      $display("FAIL trim_cfg actual=%h required=ff00000000", b_cfg); end
    checks++; if (b_rdata !== 32'h0000_00FF || b_rvalid !== 1'b1) begin failures++;
      $display("FAIL trim_read actual=%h/%b required=000000ff/1", b_rdata, b_rvalid); end
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 6; i++) begin
      c_strobe = 20'h1 << i; c_fdata = 32'h1111_1111 * (i + 1);
      tick();
    end
    c_strobe = '0; c_fdata = '0; c_rreq = 1'b1; c_raddr = 5'd2;
    tick();
    c_rreq = 1'b0;
    checks++; if (c_rdata !== 32'h3333_3333 || c_dirty !== 1'b1) begin failures++;
      $display("FAIL pre_reset_shadow actual=%h/%b required=33333333/1", c_rdata, c_dirty); end
    checks++; if (c_cfg !== RstA) begin failures++;
      $display("FAIL pre_reset_active actual=%h required=aaaaaaaa...", c_cfg[191:0]); end
    c_rst = 1'b1;
    tick();
    c_rst = 1'b0; c_rreq = 1'b1; c_raddr = 5'd2;
    checks++; if (c_cfg !== RstA || c_dirty !== 1'b0) begin failures++;
      $display("FAIL midreset_cfg actual=%h/%b required=aaaaaaaa.../0", c_cfg[191:0], c_dirty); end
    tick();
    c_rreq = 1'b0;
    checks++; if (c_rdata !== 32'hAAAA_AAAA) begin failures++;
      $display("FAIL midreset_read actual=%h required=aaaaaaaa", c_rdata); end
  endtask

  initial begin
    test_reset();
    test_write_commit();
    test_back_to_back_read();
    test_strobe_err();
    test_commit_with_write();
    test_reset_override();
    test_trimmed();
    test_midstream_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
